// File: rtl/memory_request_arbiter_pkg.sv
// Shared request/response record and field widths for the memory controller front end.
package memory_request_arbiter_pkg;

    localparam int ADDR_FIELD_WIDTH = 32;
    localparam int DATA_FIELD_WIDTH = 32;
    localparam int BYTE             = 8;
    localparam int ACCESS_ID_WIDTH  = 4;
    localparam int CORE_ID_WIDTH    = 3;

    typedef enum logic [1:0] {
        READ_REQ  = 2'd0,
        WRITE_REQ = 2'd1,
        READ_RSP  = 2'd2,
        WRITE_RSP = 2'd3
    } access_type_t;

    typedef struct packed {
        logic                               vld;
        access_type_t                       access_type;
        logic [ACCESS_ID_WIDTH-1:0]         access_id;
        logic [CORE_ID_WIDTH-1:0]           core_id;
        logic [ADDR_FIELD_WIDTH-1:0]        addr;
        logic [DATA_FIELD_WIDTH-1:0]        data;
        logic [DATA_FIELD_WIDTH/BYTE-1:0]   byte_en;
    } request_t;

endpackage

// File: rtl/memory_request_arbiter_req_fifo.sv
// Per-core request FIFO; push is ignored when full, pop is ignored when empty.
module req_fifo
    import memory_request_arbiter_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  request_t                 push_data,
    input  logic                     pop,
    output request_t                 head,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PW = $clog2(DEPTH);

    request_t          mem [DEPTH];
    logic [PW-1:0]     wr_ptr;
    logic [PW-1:0]     rd_ptr;
    logic              full;
    logic              do_push;
    logic              do_pop;

    assign full    = (count == (PW+1)'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign head    = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/memory_request_arbiter.sv
// Multi-core memory request front end: per-core FIFOs, round-robin grant onto the
// controller port, and core_id-based demux of controller responses.
module memory_request_arbiter
    import memory_request_arbiter_pkg::*;
#(
    parameter int NUM_CORES  = 4,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       reset,
    input  request_t [NUM_CORES-1:0]   core_req,
    output logic     [NUM_CORES-1:0]   core_req_ready,
    output request_t [NUM_CORES-1:0]   core_rsp,
    output request_t                   mc_req,
    input  request_t                   mc_rsp,
    output logic                       rsp_err
);

    localparam int IDX_W = $clog2(NUM_CORES);
    localparam int CW    = $clog2(FIFO_DEPTH) + 1;

    request_t          fifo_head  [NUM_CORES];
    logic              fifo_empty [NUM_CORES];
    logic [CW-1:0]     fifo_count [NUM_CORES];
    logic              fifo_pop   [NUM_CORES];

    logic [IDX_W-1:0]  rr;
    logic [IDX_W-1:0]  winner;
    logic              grant_vld;

    for (genvar i = 0; i < NUM_CORES; i++) begin : g_core
        request_t wr_data;
        logic     push;

        always_comb begin
            wr_data         = core_req[i];
            wr_data.core_id = CORE_ID_WIDTH'(i);
        end

        assign core_req_ready[i] = (fifo_count[i] != CW'(FIFO_DEPTH));
        assign push              = core_req[i].vld && core_req_ready[i];
        assign fifo_pop[i]       = grant_vld && (winner == IDX_W'(i));

        req_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
            .clk       (clk),
            .reset     (reset),
            .push      (push),
            .push_data (wr_data),
            .pop       (fifo_pop[i]),
            .head      (fifo_head[i]),
            .empty     (fifo_empty[i]),
            .count     (fifo_count[i])
        );
    end

    // Search starts one past the last winner so every busy core is reached within NUM_CORES grants.
    always_comb begin
        int idx;
        grant_vld = 1'b0;
        winner    = '0;
        idx       = 0;
        for (int k = 1; k <= NUM_CORES; k++) begin
            idx = (int'(rr) + k) % NUM_CORES;
            if (!grant_vld && !fifo_empty[idx]) begin
                grant_vld = 1'b1;
                winner    = IDX_W'(idx);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rr     <= IDX_W'(NUM_CORES - 1);
            mc_req <= '0;
        end else if (grant_vld) begin
            rr         <= winner;
            mc_req     <= fifo_head[winner];
            mc_req.vld <= 1'b1;
        end else begin
            mc_req.vld <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            core_rsp <= '0;
            rsp_err  <= 1'b0;
        end else begin
            for (int i = 0; i < NUM_CORES; i++) begin
                if (mc_rsp.vld && (mc_rsp.core_id == CORE_ID_WIDTH'(i))) begin
                    core_rsp[i] <= mc_rsp;
                end else begin
                    core_rsp[i].vld <= 1'b0;
                end
            end
            if (mc_rsp.vld && (32'(mc_rsp.core_id) >= NUM_CORES)) begin
                rsp_err <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_memory_request_arbiter.sv
// Directed bench for memory_request_arbiter with a queue-based reference model checked every cycle.
module tb_memory_request_arbiter;
    import memory_request_arbiter_pkg::*;

    localparam int NUM_CORES = 4;
    localparam int DEPTH     = 4;

    logic                      clk;
    logic                      reset;
    request_t [NUM_CORES-1:0]  core_req;
    logic     [NUM_CORES-1:0]  core_req_ready;
    request_t [NUM_CORES-1:0]  core_rsp;
    request_t                  mc_req;
    request_t                  mc_rsp;
    logic                      rsp_err;

    memory_request_arbiter #(.NUM_CORES(NUM_CORES), .FIFO_DEPTH(DEPTH)) dut (
        .clk            (clk),
        .reset          (reset),
        .core_req       (core_req),
        .core_req_ready (core_req_ready),
        .core_rsp       (core_rsp),
        .mc_req         (mc_req),
        .mc_rsp         (mc_rsp),
        .rsp_err        (rsp_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;
    bit chk_en   = 0;
    bit collect  = 0;
    logic [31:0] got [$];

    // reference model state
    request_t mq [NUM_CORES][$];
    int       m_rr;
    request_t m_mc;
    request_t m_rsp [NUM_CORES];
    logic     m_err;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic request_t mk_req(input logic v, input access_type_t t, input logic [3:0] aid,
                                        input logic [2:0] cid, input logic [31:0] a,
                                        input logic [31:0] d, input logic [3:0] be);
        request_t r;
        r.vld = v; r.access_type = t; r.access_id = aid; r.core_id = cid;
        r.addr = a; r.data = d; r.byte_en = be;
        return r;
    endfunction

    function automatic logic [NUM_CORES-1:0] rsp_vlds();
        logic [NUM_CORES-1:0] v;
        for (int i = 0; i < NUM_CORES; i++) v[i] = core_rsp[i].vld;
        return v;
    endfunction

    // Applies the arbiter's rules for one clock edge, using the inputs present before the edge.
    task automatic model_edge();
        logic acc [NUM_CORES];
        int g;
        request_t r;
        if (reset) begin
            for (int i = 0; i < NUM_CORES; i++) begin
                mq[i].delete();
                m_rsp[i] = '0;
            end
            m_rr  = NUM_CORES - 1;
            m_mc  = '0;
            m_err = 1'b0;
        end else begin
            for (int i = 0; i < NUM_CORES; i++) m_rsp[i].vld = 1'b0;
            if (mc_rsp.vld) begin
                if (int'(mc_rsp.core_id) < NUM_CORES) m_rsp[int'(mc_rsp.core_id)] = mc_rsp;
                else m_err = 1'b1;
            end
            for (int i = 0; i < NUM_CORES; i++) acc[i] = core_req[i].vld && (mq[i].size() < DEPTH);
            g = -1;
            for (int k = 1; k <= NUM_CORES; k++) begin
                if (g < 0 && mq[(m_rr + k) % NUM_CORES].size() > 0) g = (m_rr + k) % NUM_CORES;
            end
            if (g >= 0) begin
                m_mc     = mq[g].pop_front();
                m_mc.vld = 1'b1;
                m_rr     = g;
            end else begin
                m_mc.vld = 1'b0;
            end
            for (int i = 0; i < NUM_CORES; i++) begin
                if (acc[i]) begin
                    r = core_req[i];
                    r.core_id = 3'(i);
                    mq[i].push_back(r);
                end
            end
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            check("mc_req", mc_req, m_mc);
            for (int i = 0; i < NUM_CORES; i++) begin
                check($sformatf("core_rsp%0d", i), core_rsp[i], m_rsp[i]);
                check($sformatf("ready%0d", i), core_req_ready[i], mq[i].size() != DEPTH);
            end
            check("rsp_err", rsp_err, m_err);
            if (collect && mc_req.vld && mc_req.core_id == 3'd1) got.push_back(mc_req.data);
        end
    end

    task automatic do_reset();
        core_req = '0;
        mc_rsp   = '0;
        reset    = 1'b1;
        cycle();
        reset    = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int k;
        bit hs;
        bit saw_full;

        // 1: reset state
        do_reset();
        chk_en = 1;
        check("t1_ready", core_req_ready, 4'hF);
        check("t1_mc_vld", mc_req.vld, 1'b0);
        check("t1_rsp_vld", rsp_vlds(), 4'h0);
        check("t1_err", rsp_err, 1'b0);

        // 2: single request from core 2 and its response
        core_req[2] = mk_req(1, READ_REQ, 4'd5, 3'd7, 32'h40, 32'h0, 4'hF);
        cycle();
        core_req = '0;
        check("t2_no_early_grant", mc_req.vld, 1'b0);
        cycle();
        check("t2_mc_vld", mc_req.vld, 1'b1);
        check("t2_mc_core", mc_req.core_id, 3'd2);
        check("t2_mc_addr", mc_req.addr, 32'h40);
        check("t2_mc_aid", mc_req.access_id, 4'd5);
        mc_rsp = mk_req(1, READ_RSP, 4'd5, 3'd2, 32'h40, 32'hDEAD, 4'hF);
        cycle();
        mc_rsp = '0;
        check("t2_rsp_vlds", rsp_vlds(), 4'b0100);
        check("t2_rsp_data", core_rsp[2].data, 32'hDEAD);
        check("t2_rsp_aid", core_rsp[2].access_id, 4'd5);
        cycle();
        check("t2_rsp_drop", rsp_vlds(), 4'h0);

        // 3: all cores busy -> strict rotation starting at core 0
        do_reset();
        for (int n = 0; n < 10; n++) begin
            for (int i = 0; i < NUM_CORES; i++)
                core_req[i] = mk_req(1, WRITE_REQ, 4'(n), 3'(7 - i), 32'(i * 256 + n), 32'(n * 17 + i), 4'(i + 1));
            cycle();
            if (n >= 1) begin
                check("t3_vld", mc_req.vld, 1'b1);
                check("t3_order", mc_req.core_id, 3'((n - 1) % NUM_CORES));
            end
        end
        core_req = '0;
        repeat (20) cycle();

        // 4: core 1 overfills its FIFO; every entry must come out exactly once, in order
        do_reset();
        collect  = 1;
        saw_full = 0;
        k = 0;
        for (int c = 0; c < 80 && k < 6; c++) begin
            foreach (core_req[i]) if (i != 1)
                core_req[i] = (c < 4) ? mk_req(1, READ_REQ, 4'(c), 3'd0, 32'(i * 4096 + c), 32'hA000 + 32'(c), 4'h3) : '0;
            core_req[1] = mk_req(1, WRITE_REQ, 4'(k), 3'd0, 32'h1000 + 32'(k), 32'(k), 4'hF);
            hs = core_req_ready[1];
            if (!core_req_ready[1]) saw_full = 1;
            cycle();
            if (hs) k++;
        end
        core_req = '0;
        repeat (30) cycle();
        collect = 0;
        check("t4_sent", k, 6);
        check("t4_saw_full", saw_full, 1'b1);
        check("t4_count", got.size(), 6);
        for (int j = 0; j < 6; j++)
            check($sformatf("t4_data%0d", j), (j < got.size()) ? got[j] : 32'hFFFF_FFFF, 32'(j));

        // 5: response with out-of-range core_id
        mc_rsp = mk_req(1, READ_RSP, 4'd3, 3'd6, 32'h80, 32'hBEEF, 4'hF);
        cycle();
        mc_rsp = '0;
        check("t5_err", rsp_err, 1'b1);
        check("t5_rsp_vlds", rsp_vlds(), 4'h0);
        repeat (3) cycle();
        check("t5_err_sticky", rsp_err, 1'b1);

        // 6: reset with three queued entries
        do_reset();
        check("t6_err_clr", rsp_err, 1'b0);
        for (int i = 0; i < 3; i++) core_req[i] = mk_req(1, READ_REQ, 4'(i), 3'd0, 32'(i + 8), 32'h0, 4'h1);
        cycle();
        core_req = '0;
        reset = 1'b1;
        cycle();
        reset = 1'b0;
        check("t6_mc_vld", mc_req.vld, 1'b0);
        check("t6_ready", core_req_ready, 4'hF);
        repeat (3) begin
            cycle();
            check("t6_no_grant", mc_req.vld, 1'b0);
        end
        mc_rsp = mk_req(1, WRITE_RSP, 4'd9, 3'd1, 32'h0, 32'h1234, 4'h0);
        cycle();
        mc_rsp = '0;
        check("t6_rsp_routed", rsp_vlds(), 4'b0010);
        cycle();

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
